// File: rtl/fwd_history_net.sv
// Bypass network: forwards commit results to execute operands from the current
// commit broadcast or a DEPTH-cycle history of earlier results (slot 0 newest).
module fwd_history_net #(
  parameter int FU_NUM = 2,
  parameter int WB_NUM = 2,
  parameter int DEPTH  = 3,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [WB_NUM-1:0]              wb_valid,
  input  logic [WB_NUM*PREG_W-1:0]       wb_dst,
  input  logic [WB_NUM*DATA_W-1:0]       wb_data,
  input  logic [2*FU_NUM*PREG_W-1:0]     src_addr,
  output logic [2*FU_NUM-1:0]            fwd_hit,
  output logic [2*FU_NUM*DATA_W-1:0]     fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int SRC_NUM = 2 * FU_NUM;
  localparam int OCC_W   = $clog2(DEPTH + 1);

  logic [WB_NUM-1:0] h_valid [DEPTH];
  logic [PREG_W-1:0] h_dst   [DEPTH][WB_NUM];
  logic [DATA_W-1:0] h_data  [DEPTH][WB_NUM];

  // Register 0 is never forwarded, so its writes are stored already invalid.
  logic [WB_NUM-1:0] wb_live;
  always_comb begin
    wb_live = '0;
    for (int w = 0; w < WB_NUM; w++)
      wb_live[w] = wb_valid[w] && (wb_dst[w*PREG_W +: PREG_W] != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) h_valid[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) h_valid[k] <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) h_valid[k] <= h_valid[k-1];
      h_valid[0] <= wb_live;
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int k = DEPTH - 1; k > 0; k--) begin
      for (int w = 0; w < WB_NUM; w++) begin
        h_dst[k][w]  <= h_dst[k-1][w];
        h_data[k][w] <= h_data[k-1][w];
      end
    end
    for (int w = 0; w < WB_NUM; w++) begin
      h_dst[0][w]  <= wb_dst[w*PREG_W +: PREG_W];
      h_data[0][w] <= wb_data[w*DATA_W +: DATA_W];
    end
  end

  // Scan lowest priority first so the last match (newest, highest channel) wins.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int s = 0; s < SRC_NUM; s++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        for (int w = 0; w < WB_NUM; w++) begin
          if (h_valid[k][w] && (h_dst[k][w] == src_addr[s*PREG_W +: PREG_W])) begin
            fwd_hit[s]                    = 1'b1;
            fwd_data[s*DATA_W +: DATA_W]  = h_data[k][w];
          end
        end
      end
      for (int w = 0; w < WB_NUM; w++) begin
        if (wb_live[w] && (wb_dst[w*PREG_W +: PREG_W] == src_addr[s*PREG_W +: PREG_W])) begin
          fwd_hit[s]                    = 1'b1;
          fwd_data[s*DATA_W +: DATA_W]  = wb_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++)
      occupancy = occupancy + OCC_W'(|h_valid[k]);
  end

endmodule

// File: tb/tb_fwd_history_net.sv
// Self-checking bench for fwd_history_net: directed scenarios with literal
// expectations, then random traffic compared against a queue-based model.
module tb_fwd_history_net;

  localparam int FU_NUM  = 2;
  localparam int WB_NUM  = 2;
  localparam int DEPTH   = 3;
  localparam int PREG_W  = 6;
  localparam int DATA_W  = 32;
  localparam int SRC_NUM = 2 * FU_NUM;
  localparam int OCC_W   = $clog2(DEPTH + 1);

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        flush;
  logic [WB_NUM-1:0]           wb_valid;
  logic [WB_NUM*PREG_W-1:0]    wb_dst;
  logic [WB_NUM*DATA_W-1:0]    wb_data;
  logic [SRC_NUM*PREG_W-1:0]   src_addr;
  logic [SRC_NUM-1:0]          fwd_hit;
  logic [SRC_NUM*DATA_W-1:0]   fwd_data;
  logic [OCC_W-1:0]            occupancy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fwd_history_net #(
    .FU_NUM(FU_NUM), .WB_NUM(WB_NUM), .DEPTH(DEPTH),
    .PREG_W(PREG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .src_addr(src_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [WB_NUM-1:0]             v;
    logic [WB_NUM-1:0][PREG_W-1:0] d;
    logic [WB_NUM-1:0][DATA_W-1:0] x;
  } rec_t;

  rec_t hist[$];  // index 0 = result set from the most recent cycle

  function automatic rec_t cur_rec();
    rec_t r;
    r.v = wb_valid;
    r.d = wb_dst;
    r.x = wb_data;
    return r;
  endfunction

  function automatic void model_lookup(input logic [PREG_W-1:0] src,
                                       output logic hit, output logic [DATA_W-1:0] data);
    rec_t order[$];
    hit  = 1'b0;
    data = '0;
    if (src == 0) return;
    order.push_back(cur_rec());
    foreach (hist[i]) order.push_back(hist[i]);
    foreach (order[i]) begin
      for (int w = WB_NUM - 1; w >= 0; w--) begin
        if (order[i].v[w] && order[i].d[w] == src) begin
          hit  = 1'b1;
          data = order[i].x[w];
          return;
        end
      end
    end
  endfunction

  function automatic int model_occ();
    int n = 0;
    foreach (hist[i]) begin
      bit any = 0;
      for (int w = 0; w < WB_NUM; w++)
        if (hist[i].v[w] && hist[i].d[w] != 0) any = 1;
      if (any) n++;
    end
    return n;
  endfunction

  always @(posedge reset) hist.delete();

  always @(posedge clk) begin
    if (reset || flush) hist.delete();
    else begin
      hist.push_front(cur_rec());
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Compare process: mid-cycle, inputs are stable and history reflects the last edge.
  always @(negedge clk) begin
    logic             h;
    logic [DATA_W-1:0] d;
    for (int s = 0; s < SRC_NUM; s++) begin
      model_lookup(src_addr[s*PREG_W +: PREG_W], h, d);
      chk($sformatf("cmp_hit%0d", s), DATA_W'(fwd_hit[s]), DATA_W'(h));
      chk($sformatf("cmp_data%0d", s), fwd_data[s*DATA_W +: DATA_W], d);
    end
    chk("cmp_occ", DATA_W'(occupancy), DATA_W'(model_occ()));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    wb_valid = '0;
    flush    = 1'b0;
  endtask

  task automatic set_wb(input int ch, input logic v, input logic [PREG_W-1:0] dst,
                        input logic [DATA_W-1:0] data);
    wb_valid[ch]                 = v;
    wb_dst[ch*PREG_W +: PREG_W]  = dst;
    wb_data[ch*DATA_W +: DATA_W] = data;
  endtask

  task automatic set_src(input int s, input logic [PREG_W-1:0] a);
    src_addr[s*PREG_W +: PREG_W] = a;
  endtask

  function automatic logic [DATA_W-1:0] data_of(input int s);
    return fwd_data[s*DATA_W +: DATA_W];
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0;
    wb_valid = '0; wb_dst = '0; wb_data = '0; src_addr = '0;
    #2;
    chk("reset_occ", DATA_W'(occupancy), 0);
    chk("reset_hit", DATA_W'(fwd_hit), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // same-cycle forwarding
    set_wb(0, 1, 5, 32'hA5A5_0001); set_src(0, 5);
    #1;
    chk("t1_hit", DATA_W'(fwd_hit[0]), 1);
    chk("t1_data", data_of(0), 32'hA5A5_0001);
    step(); #1;
    chk("t1_occ", DATA_W'(occupancy), 1);
    chk("t1_hist_data", data_of(0), 32'hA5A5_0001);
    repeat (3) step();

    // ageing through DEPTH slots
    set_wb(0, 1, 7, 32'h11); set_src(0, 7);
    #1; chk("t2_age0", data_of(0), 32'h11);
    step(); #1; chk("t2_age1", data_of(0), 32'h11); chk("t2_occ1", DATA_W'(occupancy), 1);
    step(); #1; chk("t2_age2", data_of(0), 32'h11);
    step(); #1; chk("t2_age3", data_of(0), 32'h11);
    step(); #1; chk("t2_miss_hit", DATA_W'(fwd_hit[0]), 0);
    chk("t2_miss_data", data_of(0), 0); chk("t2_occ0", DATA_W'(occupancy), 0);

    // newest wins, current cycle beats history
    set_wb(0, 1, 9, 32'h1); set_src(0, 9);
    step(); set_wb(1, 1, 9, 32'h2);
    step(); #1; chk("t3_newest", data_of(0), 32'h2);
    set_wb(0, 1, 9, 32'h3);
    #1; chk("t3_current", data_of(0), 32'h3);

    // higher channel wins; register 0 never forwarded
    step();
    set_wb(0, 1, 4, 32'hAA); set_wb(1, 1, 4, 32'hBB); set_src(1, 4);
    #1; chk("t4_chan", data_of(1), 32'hBB);
    step(); flush = 1'b1;
    step();
    set_wb(0, 1, 0, 32'hFF); set_src(2, 0);
    #1; chk("t4_zero_hit", DATA_W'(fwd_hit[2]), 0);
    step(); #1; chk("t4_zero_occ", DATA_W'(occupancy), 0);

    // flush with simultaneous write
    set_wb(0, 1, 3, 32'h33);
    step();
    set_wb(0, 1, 6, 32'h66); flush = 1'b1; set_src(0, 3); set_src(1, 6);
    #1;
    chk("t5_pre_hit", DATA_W'(fwd_hit[1:0]), 3);
    chk("t5_pre_d3", data_of(0), 32'h33);
    chk("t5_pre_d6", data_of(1), 32'h66);
    step(); #1;
    chk("t5_post_hit", DATA_W'(fwd_hit[1:0]), 0);
    chk("t5_post_occ", DATA_W'(occupancy), 0);

    // asynchronous reset between edges
    set_wb(0, 1, 10, 32'hA0); step();
    set_wb(0, 1, 11, 32'hB0); step();
    set_wb(0, 1, 12, 32'hC0); step();
    set_src(0, 10); set_src(1, 12);
    #1; chk("t6_full_occ", DATA_W'(occupancy), 3); chk("t6_pre_data", data_of(0), 32'hA0);
    reset = 1'b1;
    #1; chk("t6_rst_occ", DATA_W'(occupancy), 0); chk("t6_rst_hit", DATA_W'(fwd_hit[1:0]), 0);
    step(); reset = 1'b0;
    set_wb(0, 1, 13, 32'hD0); set_src(0, 13);
    #1; chk("t6_cur", data_of(0), 32'hD0);
    step(); #1; chk("t6_hist", data_of(0), 32'hD0); chk("t6_occ", DATA_W'(occupancy), 1);

    // random traffic on a small register range to force collisions
    repeat (400) begin
      step();
      for (int w = 0; w < WB_NUM; w++)
        set_wb(w, 1'($urandom_range(0, 1)), PREG_W'($urandom_range(0, 15)), $urandom());
      for (int s = 0; s < SRC_NUM; s++) set_src(s, PREG_W'($urandom_range(0, 15)));
      flush = ($urandom_range(0, 15) == 0);
    end
    step();
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
